// File: rtl/mem_defs.sv
// -----------------------------------------------------------------------------
// mem_defs
// Shared types for the byte-addressable data memory (mem_32) and its read
// extension stage (mem_extend).
//   data_length_t : access width selector (byte / half / word; 2'b11 = word)
//   unsigned_t    : read extension selector (zero- or sign-extend)
//   lane_mask()   : which of the four byte lanes an access touches
// -----------------------------------------------------------------------------
package mem_defs;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'b00,
        LEN_HALF = 2'b01,
        LEN_WORD = 2'b10
    } data_length_t;

    typedef enum logic {
        UNSIG = 1'b0,
        SIG   = 1'b1
    } unsigned_t;

    // Byte lanes written for a given access width. Lane i is the byte at
    // addr+i. The reserved encoding falls into the default and acts as a word.
    function automatic logic [3:0] lane_mask(data_length_t mode);
        case (mode)
            LEN_BYTE: return 4'b0001;
            LEN_HALF: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_extend.sv
// -----------------------------------------------------------------------------
// mem_extend
// Combinational read formatter: trims the raw little-endian word fetched at
// addr to the access width and sign- or zero-extends it to 32 bits.
// Ports:
//   raw         in  32  bytes addr+3..addr, little-endian packed
//   access_mode in  2   LEN_BYTE / LEN_HALF / LEN_WORD (2'b11 acts as word)
//   sign_mode   in  1   SIG sign-extends, UNSIG zero-extends (ignored for word)
//   data_out    out 32  right-aligned, extended read data
// -----------------------------------------------------------------------------
module mem_extend
    import mem_defs::*;
(
    input  logic [31:0]  raw,
    input  data_length_t access_mode,
    input  unsigned_t    sign_mode,
    output logic [31:0]  data_out
);

    logic ext_en;

    // NOTE: every output of a combinational block gets a default before the
    // case so that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        ext_en   = (sign_mode == SIG);
        data_out = raw;
        case (access_mode)
            LEN_BYTE: data_out = {{24{ext_en & raw[7]}},  raw[7:0]};
            LEN_HALF: data_out = {{16{ext_en & raw[15]}}, raw[15:0]};
            default:  data_out = raw;
        endcase
    end

endmodule

// File: rtl/mem_32.sv
// -----------------------------------------------------------------------------
// mem_32
// Byte-addressable little-endian data memory with a 32-bit data path.
// Synchronous writes of byte/half/word, combinational extended reads.
// Address arithmetic wraps modulo SIZE; misaligned accesses are legal.
// Ports:
//   clk         in  1          write clock (rising edge)
//   reset       in  1          async active-high, clears every byte to 0
//   addr        in  ADDR_BITS  lowest byte address of the access
//   data_in     in  32         right-aligned write data
//   data_out    out 32         right-aligned, extended read data
//   wr          in  1          write enable
//   access_mode in  2          LEN_BYTE / LEN_HALF / LEN_WORD
//   sign_mode   in  1          SIG / UNSIG read extension
// -----------------------------------------------------------------------------
module mem_32
    import mem_defs::*;
#(
    parameter  int SIZE      = 256,
    localparam int ADDR_BITS = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    input  logic                 wr,
    input  data_length_t         access_mode,
    input  unsigned_t            sign_mode
);

    logic [7:0]           mem [SIZE];
    logic [ADDR_BITS-1:0] lane_addr [4];
    logic [3:0]           lane_en;
    logic [31:0]          raw_word;

    // Lane i addresses addr+i; the truncation to ADDR_BITS gives the wrap
    // from SIZE-1 back to 0 for free.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr + ADDR_BITS'(i);
        end
    end

    assign lane_en = lane_mask(access_mode);

    // NOTE: the whole array must clear asynchronously, so it is built from
    // resettable flops rather than a RAM macro, which has no reset port.
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every lane sees the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[lane_addr[i]] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Raw fetch is always four bytes; mem_extend trims it to the access width.
    // No write bypass: the read reflects stored contents only.
    assign raw_word = {mem[lane_addr[3]], mem[lane_addr[2]],
                       mem[lane_addr[1]], mem[lane_addr[0]]};

    mem_extend u_extend (
        .raw         (raw_word),
        .access_mode (access_mode),
        .sign_mode   (sign_mode),
        .data_out    (data_out)
    );

endmodule

// File: tb/tb_mem_32.sv
// -----------------------------------------------------------------------------
// tb_mem_32
// Scoreboard bench for mem_32. Stimulus tasks push the expected read value
// into a queue and raise chk_req; an independent monitor samples data_out
// 2 ns after each falling edge and compares against the queue head.
// Expected values come from a plain byte-array reference model or from
// hand-derived constants for the directed cases.
// -----------------------------------------------------------------------------
module tb_mem_32;
    import mem_defs::*;

    localparam int SIZE = 256;
    localparam int AW   = $clog2(SIZE);

    logic         clk = 1'b0;
    logic         reset;
    logic [AW-1:0] addr;
    logic [31:0]  data_in;
    logic [31:0]  data_out;
    logic         wr;
    data_length_t access_mode;
    unsigned_t    sign_mode;

    always #5 clk = ~clk;

    mem_32 #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .wr          (wr),
        .access_mode (access_mode),
        .sign_mode   (sign_mode)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          a;
    } exp_t;

    exp_t       sb[$];
    logic       chk_req = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] ref_mem [SIZE];

    // ---------------- reference model ----------------
    function automatic int nbytes(logic [1:0] m);
        if (m == 2'b00) return 1;
        if (m == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_read(int a, logic [1:0] m, logic s);
        int n;
        logic [31:0] v;
        n = nbytes(m);
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[(a + i) % SIZE]) << (8 * i));
        if (s && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void model_write(int a, logic [1:0] m, logic [31:0] d);
        for (int i = 0; i < nbytes(m); i++)
            ref_mem[(a + i) % SIZE] = 8'((d >> (8 * i)) & 32'hFF);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < SIZE; i++) ref_mem[i] = 8'h00;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input int a, input logic [1:0] m, input logic s);
        addr        = AW'(a);
        access_mode = data_length_t'(m);
        sign_mode   = unsigned_t'(s);
    endtask

    task automatic issue_read(input int a, input logic [1:0] m, input logic s,
                              input string name, input logic use_exp,
                              input logic [31:0] exp);
        @(negedge clk);
        drive(a, m, s);
        wr      = 1'b0;
        data_in = $urandom;
        sb.push_back('{name, use_exp ? exp : model_read(a, m, s), a});
        chk_req = 1'b1;
        #3 chk_req = 1'b0;
    endtask

    task automatic rd_const(input int a, input logic [1:0] m, input logic s,
                            input string name, input logic [31:0] exp);
        issue_read(a, m, s, name, 1'b1, exp);
    endtask

    task automatic rd_model(input int a, input logic [1:0] m, input logic s,
                            input string name);
        issue_read(a, m, s, name, 1'b0, 32'h0);
    endtask

    // Also checks that the pre-edge read shows the old contents.
    task automatic issue_write(input int a, input logic [1:0] m, input logic s,
                               input logic [31:0] d);
        @(negedge clk);
        drive(a, m, s);
        data_in = d;
        wr      = 1'b1;
        sb.push_back('{"rdw_old", model_read(a, m, s), a});
        chk_req = 1'b1;
        #3 chk_req = 1'b0;
        @(posedge clk);
        model_write(a, m, d);
        #1 wr = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_req) begin
                exp_t e;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: got %h, nothing expected", data_out);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.exp) begin
                        n_fail++;
                        $display("FAIL %s @%h: got %h expected %h",
                                 e.name, e.a[AW-1:0], data_out, e.exp);
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

    initial begin
        reset = 1'b1; wr = 1'b0; data_in = '0;
        drive(0, W, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        rd_const(8'h00, W, 1'b0, "reset_hold", 32'h0);
        @(negedge clk) reset = 1'b0;

        // Reset pulse with no clock edge clears prior contents.
        issue_write(8'h00, W, 1'b0, 32'hDEADBEEF);
        issue_write(8'hFC, W, 1'b0, 32'h12345678);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        model_clear();
        rd_const(8'h00, W, 1'b0, "rst_pulse_0", 32'h0);
        rd_const(8'hFC, W, 1'b0, "rst_pulse_fc", 32'h0);

        // Signed half round-trip.
        issue_write(8'h00, H, 1'b1, 32'h000FAB10);
        rd_const(8'h00, H, 1'b1, "half_sig",   32'hFFFFAB10);
        rd_const(8'h00, H, 1'b0, "half_unsig", 32'h0000AB10);
        rd_const(8'h00, W, 1'b0, "half_word",  32'h0000AB10);
        rd_const(8'h02, H, 1'b0, "half_untouched", 32'h0);

        // Word write and sub-reads.
        issue_write(8'h10, W, 1'b0, 32'h13370000);
        rd_const(8'h10, W, 1'b1, "word_rd",   32'h13370000);
        rd_const(8'h12, B, 1'b0, "byte_12",   32'h00000037);
        rd_const(8'h13, B, 1'b0, "byte_13",   32'h00000013);
        rd_const(8'h12, H, 1'b1, "half_12",   32'h00001337);
        rd_const(8'h00, H, 1'b0, "addr0_keep", 32'h0000AB10);

        // Byte write and sign extension.
        issue_write(8'h20, B, 1'b0, 32'h00000080);
        rd_const(8'h20, B, 1'b1, "byte_sig",   32'hFFFFFF80);
        rd_const(8'h20, B, 1'b0, "byte_unsig", 32'h00000080);
        issue_write(8'h21, B, 1'b0, 32'hFFFFFF7F);
        rd_const(8'h20, H, 1'b0, "half_20",    32'h00007F80);
        rd_const(8'h22, B, 1'b0, "byte_22_0",  32'h0);

        // Wrap-around and reserved mode.
        issue_write(8'hFE, W, 1'b0, 32'hAABBCCDD);
        rd_const(8'hFE, B, 1'b0, "wrap_fe", 32'h000000DD);
        rd_const(8'hFF, B, 1'b0, "wrap_ff", 32'h000000CC);
        rd_const(8'h00, B, 1'b0, "wrap_00", 32'h000000BB);
        rd_const(8'h01, B, 1'b0, "wrap_01", 32'h000000AA);
        rd_const(8'hFE, W, 1'b0, "wrap_word", 32'hAABBCCDD);
        rd_const(8'hFF, H, 1'b1, "wrap_half", 32'hFFFFBBCC);
        rd_const(8'hFE, R, 1'b1, "mode11_rd", 32'hAABBCCDD);
        issue_write(8'h30, R, 1'b0, 32'hCAFEF00D);
        rd_const(8'h30, W, 1'b0, "mode11_wr", 32'hCAFEF00D);

        // Write gating: wr low, data_in and addr churning.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr      = 1'b0;
            data_in = $urandom;
            drive(int'($urandom_range(0, SIZE - 1)), W, 1'b0);
        end
        rd_const(8'h10, W, 1'b0, "gate_10", 32'h13370000);
        rd_model(8'h30, W, 1'b0, "gate_30");

        // Randomized mix against the model.
        for (int i = 0; i < 300; i++) begin
            int a;
            logic [1:0] m;
            logic s;
            a = int'($urandom_range(0, SIZE - 1));
            m = 2'($urandom_range(0, 3));
            s = 1'($urandom);
            if ($urandom_range(0, 2) == 0) issue_write(a, m, s, $urandom);
            else                           rd_model(a, m, s, "rand_rd");
        end

        // Reset coincident with a write edge overrides the write.
        issue_write(8'h40, W, 1'b0, 32'h55667788);
        @(negedge clk);
        drive(8'h40, W, 1'b0);
        data_in = 32'h99AABBCC;
        wr      = 1'b1;
        #4 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wr = 1'b0;
        model_clear();
        rd_const(8'h40, W, 1'b0, "rst_wr_40", 32'h0);
        rd_const(8'h10, W, 1'b0, "rst_wr_10", 32'h0);
        rd_const(8'hFE, W, 1'b0, "rst_wr_fe", 32'h0);

        // Drain, bounded.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_32.md
Name: mem_32

Overview:
- Byte-addressable data memory of SIZE bytes, little-endian, with a 32-bit data path.
- Supports byte, halfword and word accesses; reads are sign- or zero-extended to 32 bits.
- Writes are synchronous; reads are combinational.
- Serves as the data memory of the processor's memory stage and is also usable standalone.

Parameters:
- SIZE, 256, memory capacity in bytes (power of two, >= 4).
- ADDR_BITS, $clog2(SIZE), address width (derived; do not override).

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all memory bytes to 0.
- addr  input  ADDR_BITS  byte address of the lowest-addressed byte of the access.
- data_in  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- data_out  output  32  read data, right-aligned and extended.
- wr  input  1  write enable, sampled at the rising edge of clk.
- access_mode  input  data_length_t  access width: LEN_BYTE, LEN_HALF or LEN_WORD.
- sign_mode  input  unsigned_t  read extension: SIG sign-extends, UNSIG zero-extends.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Storage: SIZE bytes, mem[0..SIZE-1].
- Reset:
  - While reset=1, all bytes are 0 and no write occurs.
  - Reset asserted mid-write overrides the write.
  - data_out reads 0 during and after reset.
- Write (rising edge of clk, reset=0, wr=1), little-endian:
  - LEN_BYTE: mem[addr] <= data_in[7:0].
  - LEN_HALF: mem[addr] <= data_in[7:0]; mem[addr+1] <= data_in[15:0]'s upper byte [15:8].
  - LEN_WORD: mem[addr+i] <= data_in[8i+7:8i] for i = 0..3.
  - Bytes outside the access width are untouched.
- Read (combinational, always active, independent of wr):
  - LEN_BYTE: b = mem[addr]; data_out = {24 x ext, b}.
  - LEN_HALF: h = {mem[addr+1], mem[addr]}; data_out = {16 x ext, h}.
  - LEN_WORD: data_out = {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}; sign_mode is ignored.
  - ext = MSB of the read field when sign_mode = SIG, else 0.
- Read-during-write: data_out shows the old contents until the clock edge, then the new contents in the same cycle after the edge. There is no bypass.
- Address arithmetic is modulo SIZE: multi-byte accesses wrap from SIZE-1 to 0.
- No alignment requirement; misaligned accesses are legal and behave byte-wise as above.
- The reserved access_mode encoding (2'b11) behaves as LEN_WORD.
- Latency: write 1 cycle; read 0 cycles (combinational from addr, access_mode, sign_mode and memory contents).

Decomposition:
- Package mem_defs holds:
  - typedef enum logic [1:0] data_length_t {LEN_BYTE=2'b00, LEN_HALF=2'b01, LEN_WORD=2'b10}.
  - typedef enum logic unsigned_t {UNSIG=1'b0, SIG=1'b1}.
- Sub-module mem_extend: combinational; takes a 32-bit raw word, access_mode and sign_mode, and produces the extended data_out. The core mem_32 keeps the byte array and the write-lane logic.

Test Plan:
- Reset: pulse reset with no clock edge, then read word at 0x00 and at 0xFC -> data_out = 0x00000000 both.
- Signed half round-trip:
  - At addr 0x00, LEN_HALF, SIG, wr=1 with data_in=0x000FAB10 for one edge.
  - Result: mem[0]=0x10, mem[1]=0xAB, mem[2..3] unchanged (0).
  - Read half SIG -> 0xFFFFAB10; half UNSIG -> 0x0000AB10; word -> 0x0000AB10.
- Word write at addr 0x10, LEN_WORD, data_in=0x13370000:
  - Read word -> 0x13370000.
  - Byte reads at 0x12 -> 0x00000037 and at 0x13 -> 0x00000013.
  - Half SIG read at 0x12 -> 0x00001337.
  - Addr 0x00 still reads half UNSIG 0x0000AB10.
- Byte write and sign extension:
  - Write byte 0x80 at 0x20, then read byte SIG -> 0xFFFFFF80 and UNSIG -> 0x00000080.
  - Write byte 0x7F at 0x21 (data_in upper bits = 0xFFFFFF): read half UNSIG at 0x20 -> 0x00007F80; mem[0x22] stays 0.
- Wrap-around (SIZE=256): word write 0xAABBCCDD at 0xFE -> mem[0xFE]=0xDD, mem[0xFF]=0xCC, mem[0x00]=0xBB, mem[0x01]=0xAA; word read at 0xFE -> 0xAABBCCDD.
- Write gating: hold wr=0 over several edges with changing data_in -> contents unchanged. Assert reset coincident with a wr=1 edge -> memory 0 afterwards.
